// File: rtl/uart_apb_master.sv
// Byte-stream-to-APB initiator: decodes read/write command frames from a UART rx
// byte stream, runs one APB transfer per frame and streams back a status/response frame.
module uart_apb_master #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      CLK,
  input  logic                      RSTN,
  input  logic [7:0]                rx_data_i,
  input  logic                      rx_valid_i,
  output logic                      rx_ready_o,
  output logic [7:0]                tx_data_o,
  output logic                      tx_valid_o,
  input  logic                      tx_ready_i,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR,
  output logic                      busy_o
);

  localparam logic [7:0]  CMD_WR     = 8'h57;
  localparam logic [7:0]  CMD_RD     = 8'h52;
  localparam logic [7:0]  ST_OK      = 8'h00;
  localparam logic [7:0]  ST_SLVERR  = 8'h01;
  localparam logic [7:0]  ST_TIMEOUT = 8'h02;
  localparam logic [7:0]  ST_BADCMD  = 8'hEE;
  localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_SETUP, S_ACCESS, S_RESP
  } state_t;

  state_t                    state, state_nxt;
  logic [2:0]                cnt;        // rx byte index while parsing, tx byte index in RESP
  logic [2:0]                resp_last;
  logic                      is_write;
  logic [7:0]                addr_lo;
  logic [APB_ADDR_WIDTH-1:0] addr_q;
  logic [23:0]               wdata_q;
  logic [15:0]               tcnt;
  logic [7:0]                status_q;
  logic [31:0]               rdata_q;
  logic                      rx_fire, tx_fire;

  assign rx_fire = rx_valid_i & rx_ready_o;
  assign tx_fire = tx_valid_o & tx_ready_i;
  assign busy_o  = (state != S_IDLE);

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    state_nxt  = state;
    rx_ready_o = 1'b0;
    tx_valid_o = 1'b0;
    tx_data_o  = 8'h00;
    PSEL       = 1'b0;
    PENABLE    = 1'b0;
    unique case (state)
      S_IDLE: begin
        rx_ready_o = 1'b1;
        if (rx_valid_i)
          state_nxt = (rx_data_i == CMD_WR || rx_data_i == CMD_RD) ? S_ADDR : S_RESP;
      end
      S_ADDR: begin
        rx_ready_o = 1'b1;
        if (rx_valid_i && cnt == 3'd1) state_nxt = is_write ? S_DATA : S_SETUP;
      end
      S_DATA: begin
        rx_ready_o = 1'b1;
        if (rx_valid_i && cnt == 3'd3) state_nxt = S_SETUP;
      end
      S_SETUP: begin
        PSEL      = 1'b1;
        state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        // PREADY has priority over a timeout expiring in the same cycle
        if (PREADY || tcnt == TMO_LAST) state_nxt = S_RESP;
      end
      S_RESP: begin
        tx_valid_o = 1'b1;
        unique case (cnt)
          3'd0:    tx_data_o = status_q;
          3'd1:    tx_data_o = rdata_q[7:0];
          3'd2:    tx_data_o = rdata_q[15:8];
          3'd3:    tx_data_o = rdata_q[23:16];
          3'd4:    tx_data_o = rdata_q[31:24];
          default: tx_data_o = 8'h00;
        endcase
        if (tx_ready_i && cnt == resp_last) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state     <= S_IDLE;
      cnt       <= '0;
      resp_last <= '0;
      is_write  <= 1'b0;
      addr_lo   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      tcnt      <= '0;
      status_q  <= '0;
      rdata_q   <= '0;
      PADDR     <= '0;
      PWDATA    <= '0;
      PWRITE    <= 1'b0;
    end else begin
      state <= state_nxt;
      unique case (state)
        S_IDLE: if (rx_fire) begin
          cnt       <= '0;
          is_write  <= (rx_data_i == CMD_WR);
          status_q  <= ST_BADCMD;
          resp_last <= '0;
        end
        S_ADDR: if (rx_fire) begin
          if (cnt == 3'd0) begin
            addr_lo <= rx_data_i;
            cnt     <= 3'd1;
          end else begin
            addr_q <= APB_ADDR_WIDTH'({rx_data_i, addr_lo});
            cnt    <= '0;
            if (!is_write) begin
              PADDR  <= APB_ADDR_WIDTH'({rx_data_i, addr_lo});
              PWDATA <= '0;
              PWRITE <= 1'b0;
            end
          end
        end
        S_DATA: if (rx_fire) begin
          cnt <= cnt + 3'd1;
          unique case (cnt)
            3'd0: wdata_q[7:0]   <= rx_data_i;
            3'd1: wdata_q[15:8]  <= rx_data_i;
            3'd2: wdata_q[23:16] <= rx_data_i;
            default: begin
              PADDR  <= addr_q;
              PWDATA <= {rx_data_i, wdata_q};
              PWRITE <= 1'b1;
              cnt    <= '0;
            end
          endcase
        end
        S_SETUP: begin
          tcnt      <= '0;
          rdata_q   <= '0;
          resp_last <= is_write ? 3'd0 : 3'd4;
        end
        S_ACCESS: begin
          if (PREADY) begin
            rdata_q  <= PRDATA;
            status_q <= PSLVERR ? ST_SLVERR : ST_OK;
          end else if (tcnt == TMO_LAST) begin
            status_q <= ST_TIMEOUT;
          end else begin
            tcnt <= tcnt + 16'd1;
          end
        end
        S_RESP: if (tx_fire) cnt <= (cnt == resp_last) ? 3'd0 : cnt + 3'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_apb_master.sv
// Self-checking bench for uart_apb_master: directed frames from the test plan plus
// randomized frames checked against a frame-level reference model.
module tb_uart_apb_master;
  localparam int AW = 12;
  localparam int T  = 8;

  logic          CLK = 1'b0;
  logic          RSTN;
  logic [7:0]    rx_data_i;
  logic          rx_valid_i;
  logic          rx_ready_o;
  logic [7:0]    tx_data_o;
  logic          tx_valid_o;
  logic          tx_ready_i;
  logic [AW-1:0] PADDR;
  logic [31:0]   PWDATA;
  logic          PWRITE, PSEL, PENABLE;
  logic [31:0]   PRDATA;
  logic          PREADY, PSLVERR;
  logic          busy_o;

  uart_apb_master #(.APB_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(T)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .busy_o(busy_o)
  );

  always #5 CLK = ~CLK;

  int vectors = 0, miscompares = 0;

  // APB slave: PREADY after wait_cfg wait states (large value = never ready)
  int          wait_cfg = 0;
  logic        err_cfg = 1'b0;
  logic [31:0] prdata_cfg = '0;
  int          acc_cnt;
  assign PREADY  = PSEL && PENABLE && (acc_cnt == wait_cfg);
  assign PSLVERR = err_cfg;
  assign PRDATA  = prdata_cfg;
  always @(posedge CLK or negedge RSTN)
    if (!RSTN) acc_cnt <= 0;
    else if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;

  // tx_ready_i modes: 0 always ready, 1 ready one cycle in three, 2 never ready
  int tx_mode = 0;
  initial begin
    int k = 0;
    tx_ready_i = 1'b1;
    forever begin
      @(negedge CLK);
      k++;
      case (tx_mode)
        0:       tx_ready_i = 1'b1;
        1:       tx_ready_i = (k % 3 == 0);
        default: tx_ready_i = 1'b0;
      endcase
    end
  end

  // Monitor, sampled mid-low-phase once inputs have settled
  int          cyc = 0;
  logic [7:0]  tx_q[$];
  int          tx_cyc_q[$], rx_cyc_q[$];
  int          setups, accs, proto_err = 0, stab_err = 0;
  int          last_rx_cyc, first_tx_cyc;
  logic [AW-1:0] obs_addr;
  logic [31:0] obs_wdata;
  logic        obs_write;
  bit          prev_stall = 0;
  logic [7:0]  prev_data;

  always @(negedge RSTN) prev_stall = 0;
  always @(negedge CLK) begin
    #2;
    cyc++;
    if (RSTN) begin
      if (rx_valid_i && rx_ready_o) begin last_rx_cyc = cyc; rx_cyc_q.push_back(cyc); end
      if (tx_valid_o && first_tx_cyc < 0) first_tx_cyc = cyc;
      if (prev_stall && (!tx_valid_o || tx_data_o !== prev_data)) stab_err++;
      if (tx_valid_o && tx_ready_i) begin tx_q.push_back(tx_data_o); tx_cyc_q.push_back(cyc); end
      prev_stall = tx_valid_o && !tx_ready_i;
      prev_data  = tx_data_o;
      if (tx_valid_o && rx_ready_o) proto_err++;
      if (PENABLE && !PSEL) proto_err++;
      if (PSEL && !PENABLE) begin setups++; obs_addr = PADDR; obs_wdata = PWDATA; obs_write = PWRITE; end
      if (PSEL && PENABLE) accs++;
    end
  end

  // Reference model: response bytes packed little-endian, response length, ACCESS cycles
  function automatic void model(input logic [7:0] cmd, input int w, input logic err,
                                input logic [31:0] prd, output logic [39:0] resp,
                                output int len, output int acc);
    logic [7:0] st;
    bit tmo;
    if (cmd != 8'h57 && cmd != 8'h52) begin
      resp = 40'hEE; len = 1; acc = 0;
    end else begin
      tmo = (w >= T);
      acc = tmo ? T : w + 1;
      st  = tmo ? 8'h02 : (err ? 8'h01 : 8'h00);
      if (cmd == 8'h57) begin resp = {32'h0, st}; len = 1; end
      else begin resp = {(tmo ? 32'h0 : prd), st}; len = 5; end
    end
  endfunction

  task automatic clear_obs();
    tx_q.delete(); tx_cyc_q.delete(); rx_cyc_q.delete();
    setups = 0; accs = 0; first_tx_cyc = -1; last_rx_cyc = -1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok = 0;
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    for (int k = 0; k < 400 && !ok; k++) begin
      #2 ok = rx_ready_o;
      @(negedge CLK);
    end
    rx_valid_i = 1'b0;
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL rx_accept: byte %02h never accepted, rx_ready_o stayed 0", b); end
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [15:0] addr, input logic [31:0] wd);
    send_byte(cmd);
    if (cmd == 8'h57 || cmd == 8'h52) begin
      send_byte(addr[7:0]); send_byte(addr[15:8]);
      if (cmd == 8'h57) for (int i = 0; i < 4; i++) send_byte(wd[8*i +: 8]);
    end
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int k = 0; k < 400 && !ok; k++) begin
      #2 ok = !busy_o;
      @(negedge CLK);
    end
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL idle_wait: busy_o still 1 after 400 cycles, required 0"); end
  endtask

  logic [39:0] obs_resp;
  int          obs_len;

  task automatic run_frame(input logic [7:0] cmd, input logic [15:0] addr, input logic [31:0] wd,
                           input int w, input logic err, input logic [31:0] prd);
    wait_cfg = w; err_cfg = err; prdata_cfg = prd;
    clear_obs();
    send_frame(cmd, addr, wd);
    wait_idle();
    obs_resp = '0;
    obs_len  = tx_q.size();
    foreach (tx_q[i]) if (i < 5) obs_resp[8*i +: 8] = tx_q[i];
  endtask

  task automatic test_reset();
    RSTN = 1'b0; rx_valid_i = 1'b0; rx_data_i = '0;
    #13;
    vectors++;
    if ({rx_ready_o, tx_valid_o, tx_data_o, PSEL, PENABLE, PWRITE, PADDR, PWDATA, busy_o} !==
        {1'b1, 1'b0, 8'h00, 3'b000, {AW{1'b0}}, 32'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_state: rdy=%b txv=%b txd=%02h psel=%b pen=%b pw=%b paddr=%h pwdata=%h busy=%b, required 1 0 00 0 0 0 0 0 0",
               rx_ready_o, tx_valid_o, tx_data_o, PSEL, PENABLE, PWRITE, PADDR, PWDATA, busy_o);
    end
    @(negedge CLK); RSTN = 1'b1; @(negedge CLK);
  endtask

  task automatic test_write();
    tx_mode = 0;
    run_frame(8'h57, 16'h0010, 32'h12345678, 0, 1'b0, 32'h0);
    vectors++;
    if (obs_resp !== 40'h00 || obs_len != 1) begin miscompares++;
      $display("FAIL write_resp: got %h len %0d, required 00 len 1", obs_resp, obs_len); end
    vectors++;
    if (setups != 1 || accs != 1) begin miscompares++;
      $display("FAIL write_phases: setup %0d access %0d, required 1 1", setups, accs); end
    vectors++;
    if ({obs_addr, obs_wdata, obs_write} !== {12'h010, 32'h12345678, 1'b1}) begin miscompares++;
      $display("FAIL write_bus: addr %h wdata %h write %b, required 010 12345678 1", obs_addr, obs_wdata, obs_write); end
    vectors++;
    if (first_tx_cyc - last_rx_cyc != 3) begin miscompares++;
      $display("FAIL write_latency: %0d cycles, required 3", first_tx_cyc - last_rx_cyc); end
    vectors++;
    if ({PADDR, PWDATA, PWRITE, PSEL} !== {12'h010, 32'h12345678, 1'b1, 1'b0}) begin miscompares++;
      $display("FAIL write_hold: paddr %h pwdata %h pwrite %b psel %b, required 010 12345678 1 0", PADDR, PWDATA, PWRITE, PSEL); end
  endtask

  task automatic test_read_wait();
    tx_mode = 0;
    run_frame(8'h52, 16'h0014, 32'h0, 3, 1'b0, 32'hA5A55A5A);
    vectors++;
    if (obs_resp !== 40'hA5A55A5A00 || obs_len != 5) begin miscompares++;
      $display("FAIL read_resp: got %h len %0d, required a5a55a5a00 len 5", obs_resp, obs_len); end
    vectors++;
    if (accs != 4 || first_tx_cyc - last_rx_cyc != 6) begin miscompares++;
      $display("FAIL read_wait: access %0d latency %0d, required 4 6", accs, first_tx_cyc - last_rx_cyc); end
    vectors++;
    if ({obs_addr, obs_wdata, obs_write} !== {12'h014, 32'h0, 1'b0}) begin miscompares++;
      $display("FAIL read_bus: addr %h wdata %h write %b, required 014 0 0", obs_addr, obs_wdata, obs_write); end
    vectors++;
    if (tx_cyc_q.size() != 5 || tx_cyc_q[4] - tx_cyc_q[0] != 4) begin miscompares++;
      $display("FAIL read_burst: %0d bytes, span not 4 consecutive cycles", tx_cyc_q.size()); end
  endtask

  task automatic test_slverr();
    tx_mode = 0;
    run_frame(8'h57, 16'h0020, 32'hCAFEF00D, 1, 1'b1, 32'h0);
    vectors++;
    if (obs_resp !== 40'h01 || obs_len != 1) begin miscompares++;
      $display("FAIL slverr_write: got %h len %0d, required 01 len 1", obs_resp, obs_len); end
    run_frame(8'h52, 16'h0024, 32'h0, 0, 1'b1, 32'hDEADBEEF);
    vectors++;
    if (obs_resp !== 40'hDEADBEEF01 || obs_len != 5) begin miscompares++;
      $display("FAIL slverr_read: got %h len %0d, required deadbeef01 len 5", obs_resp, obs_len); end
  endtask

  task automatic test_timeout();
    tx_mode = 0;
    run_frame(8'h52, 16'h0030, 32'h0, 1000, 1'b0, 32'h12345678);
    vectors++;
    if (obs_resp !== 40'h0000000002 || obs_len != 5) begin miscompares++;
      $display("FAIL timeout_resp: got %h len %0d, required 0000000002 len 5", obs_resp, obs_len); end
    vectors++;
    if (accs != T || first_tx_cyc - last_rx_cyc != 2 + T) begin miscompares++;
      $display("FAIL timeout_len: access %0d latency %0d, required %0d %0d", accs, first_tx_cyc - last_rx_cyc, T, 2 + T); end
    run_frame(8'h52, 16'h0034, 32'h0, T - 1, 1'b0, 32'h0BADF00D);
    vectors++;
    if (obs_resp !== 40'h0BADF00D00 || accs != T) begin miscompares++;
      $display("FAIL timeout_edge: got %h access %0d, required 0badf00d00 access %0d", obs_resp, accs, T); end
  endtask

  task automatic test_bad_cmd();
    logic [31:0] prd = $urandom;
    tx_mode = 0;
    run_frame(8'h41, 16'h0, 32'h0, 0, 1'b0, 32'h0);
    vectors++;
    if (obs_resp !== 40'hEE || obs_len != 1 || setups != 0 || first_tx_cyc - last_rx_cyc != 1) begin miscompares++;
      $display("FAIL bad_cmd: got %h len %0d setups %0d latency %0d, required ee 1 0 1",
               obs_resp, obs_len, setups, first_tx_cyc - last_rx_cyc); end
    tx_mode = 1;
    run_frame(8'h52, 16'h0044, 32'h0, 1, 1'b0, prd);
    vectors++;
    if (obs_resp !== {prd, 8'h00} || obs_len != 5) begin miscompares++;
      $display("FAIL slow_tx_read: got %h len %0d, required %h len 5", obs_resp, obs_len, {prd, 8'h00}); end
    vectors++;
    if (stab_err != 0 || proto_err != 0) begin miscompares++;
      $display("FAIL slow_tx_stable: stability errors %0d protocol errors %0d, required 0 0", stab_err, proto_err); end
    tx_mode = 0;
  endtask

  task automatic test_back_to_back();
    tx_mode = 0; wait_cfg = 0; err_cfg = 1'b0; prdata_cfg = 32'h11223344;
    clear_obs();
    send_frame(8'h52, 16'h0050, 32'h0);
    send_frame(8'h57, 16'h0054, 32'h55667788);
    wait_idle();
    vectors++;
    if (tx_q.size() != 6 || rx_cyc_q.size() != 10) begin miscompares++;
      $display("FAIL b2b_count: tx %0d rx %0d, required 6 10", tx_q.size(), rx_cyc_q.size()); end
    else begin
      vectors++;
      if ({tx_q[4], tx_q[3], tx_q[2], tx_q[1], tx_q[0], tx_q[5]} !== 48'h11223344_00_00) begin miscompares++;
        $display("FAIL b2b_bytes: %02h %02h %02h %02h %02h %02h, required 00 44 33 22 11 00",
                 tx_q[0], tx_q[1], tx_q[2], tx_q[3], tx_q[4], tx_q[5]); end
      vectors++;
      if (tx_cyc_q[4] - tx_cyc_q[0] != 4 || rx_cyc_q[3] != tx_cyc_q[4] + 1) begin miscompares++;
        $display("FAIL b2b_timing: tx span %0d, next cmd %0d cycles after last byte, required 4 1",
                 tx_cyc_q[4] - tx_cyc_q[0], rx_cyc_q[3] - tx_cyc_q[4]); end
    end
    vectors++;
    if ({obs_addr, obs_wdata, obs_write} !== {12'h054, 32'h55667788, 1'b1}) begin miscompares++;
      $display("FAIL b2b_bus: addr %h wdata %h write %b, required 054 55667788 1", obs_addr, obs_wdata, obs_write); end
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    tx_mode = 0; wait_cfg = 1000;
    clear_obs();
    send_frame(8'h52, 16'h0060, 32'h0);
    for (int k = 0; k < 30 && !seen; k++) begin #2 seen = PENABLE; if (!seen) @(negedge CLK); end
    #1 RSTN = 1'b0;
    #1;
    vectors++;
    if (!seen || {PSEL, PENABLE, busy_o, tx_valid_o, rx_ready_o, PADDR} !== {5'b00001, {AW{1'b0}}}) begin miscompares++;
      $display("FAIL reset_access: seen %b psel %b pen %b busy %b txv %b rdy %b paddr %h, required 1 0 0 0 0 1 0",
               seen, PSEL, PENABLE, busy_o, tx_valid_o, rx_ready_o, PADDR); end
    @(negedge CLK); RSTN = 1'b1; @(negedge CLK);
    seen = 0; tx_mode = 2; wait_cfg = 0;
    send_frame(8'h52, 16'h0064, 32'h0);
    for (int k = 0; k < 30 && !seen; k++) begin #2 seen = tx_valid_o; if (!seen) @(negedge CLK); end
    #1 RSTN = 1'b0;
    #1;
    vectors++;
    if (!seen || {tx_valid_o, tx_data_o, PSEL, busy_o, rx_ready_o} !== {1'b0, 8'h00, 2'b00, 1'b1}) begin miscompares++;
      $display("FAIL reset_resp: seen %b txv %b txd %02h psel %b busy %b rdy %b, required 1 0 00 0 0 1",
               seen, tx_valid_o, tx_data_o, PSEL, busy_o, rx_ready_o); end
    @(negedge CLK); RSTN = 1'b1; tx_mode = 0; @(negedge CLK);
    run_frame(8'h57, 16'h0068, 32'h9ABCDEF0, 2, 1'b0, 32'h0);
    vectors++;
    if (obs_resp !== 40'h00 || obs_len != 1 || setups != 1 || {obs_addr, obs_wdata} !== {12'h068, 32'h9ABCDEF0}) begin miscompares++;
      $display("FAIL reset_recover: resp %h len %0d setups %0d addr %h wdata %h, required 00 1 1 068 9abcdef0",
               obs_resp, obs_len, setups, obs_addr, obs_wdata); end
  endtask

  task automatic test_random();
    logic [7:0]  cmd;
    logic [15:0] addr;
    logic [31:0] wd, prd;
    logic        err;
    int          w, elen, eacc, r;
    logic [39:0] eresp;
    logic [AW-1:0] held_addr = PADDR;
    for (int n = 0; n < 30; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        cmd = 8'($urandom_range(0, 255));
        if (cmd == 8'h57 || cmd == 8'h52) cmd = 8'h00;
      end else cmd = (r < 5) ? 8'h57 : 8'h52;
      addr = 16'($urandom); wd = $urandom; prd = $urandom; err = 1'($urandom);
      w = ($urandom_range(0, 5) == 0) ? $urandom_range(T - 1, T + 2) : $urandom_range(0, 4);
      tx_mode = $urandom_range(0, 1);
      model(cmd, w, err, prd, eresp, elen, eacc);
      run_frame(cmd, addr, wd, w, err, prd);
      if (cmd == 8'h57 || cmd == 8'h52) held_addr = addr[AW-1:0];
      vectors++;
      if (obs_resp !== eresp || obs_len != elen) begin miscompares++;
        $display("FAIL rand_resp[%0d]: cmd %02h got %h len %0d, required %h len %0d", n, cmd, obs_resp, obs_len, eresp, elen); end
      vectors++;
      if (setups != (elen == 1 && eresp[7:0] == 8'hEE ? 0 : 1) || accs != eacc) begin miscompares++;
        $display("FAIL rand_phases[%0d]: setups %0d access %0d, required access %0d", n, setups, accs, eacc); end
      vectors++;
      if (first_tx_cyc - last_rx_cyc != (eacc == 0 ? 1 : 2 + eacc)) begin miscompares++;
        $display("FAIL rand_latency[%0d]: %0d, required %0d", n, first_tx_cyc - last_rx_cyc, (eacc == 0 ? 1 : 2 + eacc)); end
      if (eacc != 0) begin
        vectors++;
        if ({obs_addr, obs_wdata, obs_write} !== {addr[AW-1:0], (cmd == 8'h57 ? wd : 32'h0), cmd == 8'h57}) begin miscompares++;
          $display("FAIL rand_bus[%0d]: addr %h wdata %h write %b, required %h %h %b", n, obs_addr, obs_wdata, obs_write,
                   addr[AW-1:0], (cmd == 8'h57 ? wd : 32'h0), cmd == 8'h57); end
      end
      vectors++;
      if (PADDR !== held_addr) begin miscompares++;
        $display("FAIL rand_hold[%0d]: paddr %h, required %h", n, PADDR, held_addr); end
    end
    tx_mode = 0;
  endtask

  task automatic test_protocol();
    vectors++;
    if (proto_err != 0 || stab_err != 0) begin miscompares++;
      $display("FAIL protocol: protocol errors %0d stability errors %0d, required 0 0", proto_err, stab_err); end
  endtask

  initial begin
    rx_valid_i = 1'b0; rx_data_i = '0; RSTN = 1'b0;
    clear_obs();
    test_reset();
    test_write();
    test_read_wait();
    test_slverr();
    test_timeout();
    test_bad_cmd();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_protocol();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
